// File: rtl/tx_burst_pkg.sv
// Shared state encoding and default lengths for the TX burst sequencer.
// Also holds the state-successor helper used by the sequencer FSM.
package tx_burst_pkg;

  typedef enum logic [2:0] {
    ST_PRIME   = 3'd0,
    ST_ARMED   = 3'd1,
    ST_HEAD    = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_TAIL    = 3'd4,
    ST_GUARD   = 3'd5
  } burst_state_t;

  localparam int DEF_IQ_BITS         = 8;
  localparam int DEF_PRIME_SYMBOLS   = 2;
  localparam int DEF_HEAD_SYMBOLS    = 3;
  localparam int DEF_PAYLOAD_SYMBOLS = 142;
  localparam int DEF_TAIL_SYMBOLS    = 3;
  localparam int DEF_GUARD_SYMBOLS   = 8;
  localparam int DEF_LATENCY_SYMBOLS = 2;

  function automatic int max5(
    input int a,
    input int b,
    input int c,
    input int d,
    input int e
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

  function automatic burst_state_t next_state(
    input burst_state_t s
  );
    burst_state_t n;
    unique case (s)
      ST_PRIME:   n = ST_ARMED;
      ST_HEAD:    n = ST_PAYLOAD;
      ST_PAYLOAD: n = ST_TAIL;
      ST_TAIL:    n = ST_GUARD;
      ST_GUARD:   n = ST_ARMED;
      default:    n = ST_ARMED;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/symbol_edge_detect.sv
// Rising-edge detector on the modulator's next-symbol level.
// History resets high so a strobe held through reset is not an edge.
module symbol_edge_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic strobe,
  output logic strobe_edge
);

  logic r_prev;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= strobe;
    end
  end

  assign strobe_edge = strobe & ~r_prev;

endmodule

// File: rtl/tx_burst_sequencer.sv
// Burst framing FSM: prime, arm, head/payload/tail, guard, with
// a symbol-aligned enable pipeline gating the RF-chain I/Q.
module tx_burst_sequencer
  import tx_burst_pkg::*;
#(
  parameter int IQ_BITS         = DEF_IQ_BITS,
  parameter int PRIME_SYMBOLS   = DEF_PRIME_SYMBOLS,
  parameter int HEAD_SYMBOLS    = DEF_HEAD_SYMBOLS,
  parameter int PAYLOAD_SYMBOLS = DEF_PAYLOAD_SYMBOLS,
  parameter int TAIL_SYMBOLS    = DEF_TAIL_SYMBOLS,
  parameter int GUARD_SYMBOLS   = DEF_GUARD_SYMBOLS,
  parameter int LATENCY_SYMBOLS = DEF_LATENCY_SYMBOLS
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               next_symbol_strobe,
  input  logic [IQ_BITS-1:0] modulator_inphase,
  input  logic [IQ_BITS-1:0] modulator_quadrature,
  output logic               current_symbol,
  input  logic               fire_burst,
  output logic               is_armed,
  input  logic               payload_bit,
  input  logic               payload_valid,
  output logic               payload_ready,
  output logic               underrun,
  output logic               burst_done,
  output logic [IQ_BITS-1:0] rfchain_inphase,
  output logic [IQ_BITS-1:0] rfchain_quadrature,
  output logic               rfchain_tx_enable
);

  localparam int CNT_W = $clog2(max5(PRIME_SYMBOLS,
    HEAD_SYMBOLS, PAYLOAD_SYMBOLS, TAIL_SYMBOLS,
    GUARD_SYMBOLS)) + 1;
  localparam int LAT = LATENCY_SYMBOLS;

  if (GUARD_SYMBOLS < LATENCY_SYMBOLS ||
      PRIME_SYMBOLS < 1 || HEAD_SYMBOLS < 1 ||
      PAYLOAD_SYMBOLS < 1 || TAIL_SYMBOLS < 1 ||
      GUARD_SYMBOLS < 1 || LATENCY_SYMBOLS < 1 ||
      IQ_BITS < 1) begin : g_param_err
    $error("tx_burst_sequencer: illegal parameters");
  end

  burst_state_t       r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_cur;
  logic               r_is_armed;
  logic               r_underrun;
  logic               r_burst_done;
  logic [LAT-1:0]     r_en_sr;
  logic               r_tx_en;
  logic [IQ_BITS-1:0] r_i;
  logic [IQ_BITS-1:0] r_q;

  logic               w_edge;
  logic               w_fire_ok;
  burst_state_t       w_state;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [CNT_W-1:0]   w_len;
  logic               w_last;
  logic               w_in_burst;

  symbol_edge_detect u_edge (
    .clock       (clock),
    .reset_n     (reset_n),
    .strobe      (next_symbol_strobe),
    .strobe_edge (w_edge)
  );

  // An accepted fire lets a same-cycle edge issue the first head symbol.
  always_comb begin
    w_fire_ok  = r_is_armed & fire_burst;
    w_state    = w_fire_ok ? ST_HEAD : r_state;
    w_cnt_inc  = (w_fire_ok ? '0 : r_cnt) + 1'b1;
    w_len      = '0;
    unique case (w_state)
      ST_PRIME:   w_len = CNT_W'(PRIME_SYMBOLS);
      ST_HEAD:    w_len = CNT_W'(HEAD_SYMBOLS);
      ST_PAYLOAD: w_len = CNT_W'(PAYLOAD_SYMBOLS);
      ST_TAIL:    w_len = CNT_W'(TAIL_SYMBOLS);
      ST_GUARD:   w_len = CNT_W'(GUARD_SYMBOLS);
      default:    w_len = '0;
    endcase
    w_last     = (w_cnt_inc == w_len);
    w_in_burst = (w_state == ST_HEAD) |
                 (w_state == ST_PAYLOAD) |
                 (w_state == ST_TAIL);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_PRIME;
      r_cnt        <= '0;
      r_cur        <= 1'b1;
      r_is_armed   <= 1'b0;
      r_underrun   <= 1'b0;
      r_burst_done <= 1'b0;
      r_en_sr      <= '0;
      r_tx_en      <= 1'b0;
      r_i          <= '0;
      r_q          <= '0;
    end else begin
      r_burst_done <= 1'b0;
      r_tx_en      <= r_en_sr[LAT-1];
      r_i          <= r_en_sr[LAT-1] ? modulator_inphase : '0;
      r_q          <= r_en_sr[LAT-1] ? modulator_quadrature : '0;
      if (w_fire_ok) begin
        r_state    <= ST_HEAD;
        r_cnt      <= '0;
        r_underrun <= 1'b0;
        r_is_armed <= 1'b0;
      end else if (r_state == ST_ARMED) begin
        r_is_armed <= 1'b1;
      end
      if (w_edge) begin
        for (int i = LAT - 1; i > 0; i--) begin
          r_en_sr[i] <= r_en_sr[i-1];
        end
        r_en_sr[0] <= w_in_burst;
        unique case (w_state)
          ST_HEAD, ST_TAIL: r_cur <= 1'b0;
          ST_PAYLOAD: begin
            r_cur <= payload_valid ? payload_bit : 1'b1;
            if (!payload_valid) r_underrun <= 1'b1;
          end
          default: r_cur <= 1'b1;
        endcase
        if (w_state != ST_ARMED) begin
          if (w_last) begin
            r_state      <= next_state(w_state);
            r_cnt        <= '0;
            r_is_armed   <= (w_state == ST_PRIME);
            r_burst_done <= (w_state == ST_GUARD);
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
      end
    end
  end

  assign payload_ready      = w_edge & payload_valid &
                              (w_state == ST_PAYLOAD);
  assign current_symbol     = r_cur;
  assign is_armed           = r_is_armed;
  assign underrun           = r_underrun;
  assign burst_done         = r_burst_done;
  assign rfchain_tx_enable  = r_tx_en;
  assign rfchain_inphase    = r_i;
  assign rfchain_quadrature = r_q;

endmodule

// File: tb/tb_tx_burst_sequencer.sv
// Scoreboard bench for tx_burst_sequencer: stimulus pushes per-edge
// expectations, a negedge monitor pops and compares them.
module tb_tx_burst_sequencer;

  localparam int PAY = 142;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       next_symbol_strobe = 1'b0;
  logic [7:0] modulator_inphase = 8'h3C;
  logic [7:0] modulator_quadrature = 8'hC3;
  logic       current_symbol;
  logic       fire_burst = 1'b0;
  logic       is_armed;
  logic       payload_bit = 1'b0;
  logic       payload_valid = 1'b0;
  logic       payload_ready;
  logic       underrun;
  logic       burst_done;
  logic [7:0] rfchain_inphase;
  logic [7:0] rfchain_quadrature;
  logic       rfchain_tx_enable;

  tx_burst_sequencer dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .next_symbol_strobe   (next_symbol_strobe),
    .modulator_inphase    (modulator_inphase),
    .modulator_quadrature (modulator_quadrature),
    .current_symbol       (current_symbol),
    .fire_burst           (fire_burst),
    .is_armed             (is_armed),
    .payload_bit          (payload_bit),
    .payload_valid        (payload_valid),
    .payload_ready        (payload_ready),
    .underrun             (underrun),
    .burst_done           (burst_done),
    .rfchain_inphase      (rfchain_inphase),
    .rfchain_quadrature   (rfchain_quadrature),
    .rfchain_tx_enable    (rfchain_tx_enable)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit sym;
    bit txen;
    bit pr;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         pr_cnt = 0;
  bit         h0 = 1'b0;
  bit         h1 = 1'b0;
  logic [7:0] pattern = 8'hA5;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, req, $time);
    end
  endfunction

  // txen expected at an edge = burst membership two edges earlier
  task automatic push(input bit s, input bit inb, input bit pr);
    exp_t e;
    e.sym  = s;
    e.txen = h1;
    e.pr   = pr;
    exp_q.push_back(e);
    h1 = h0;
    h0 = inb;
  endtask

  task automatic sym();
    next_symbol_strobe = 1'b1;
    @(posedge clock); #1;
    next_symbol_strobe = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic flush_model();
    exp_q.delete();
    h0 = 1'b0;
    h1 = 1'b0;
  endtask

  task automatic burst(input int bad, input bit fire_mid,
                       input int rst_at, input bit fire_done);
    int ptr;
    int n_pr;
    bit v;
    bit b;
    ptr = 0;
    n_pr = 0;
    pr_cnt = 0;
    fire_burst = 1'b1;
    @(posedge clock); #1;
    fire_burst = 1'b0;
    chk("fire_drops_armed", is_armed, 0);
    chk("fire_clears_underrun", underrun, 0);
    for (int i = 0; i < 3; i++) begin
      push(1'b0, 1'b1, 1'b0);
      sym();
    end
    for (int i = 0; i < PAY; i++) begin
      if (i == rst_at) begin
        chk("pre_rst_txen", rfchain_tx_enable, 1);
        chk("pre_rst_underrun", underrun, 1);
        chk("pre_rst_symbol", current_symbol, 0);
        chk("pre_rst_iq", rfchain_inphase, 8'h3C);
        #2;
        reset_n = 1'b0;
        flush_model();
        #1;
        chk("rst_symbol", current_symbol, 1);
        chk("rst_armed", is_armed, 0);
        chk("rst_pready", payload_ready, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_done", burst_done, 0);
        chk("rst_txen", rfchain_tx_enable, 0);
        chk("rst_iq_i", rfchain_inphase, 0);
        chk("rst_iq_q", rfchain_quadrature, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        return;
      end
      v = (i != bad);
      b = pattern[7 - (ptr % 8)];
      payload_valid = v;
      payload_bit = b;
      push(v ? b : 1'b1, 1'b1, v);
      if (v) begin
        ptr++;
        n_pr++;
      end
      if (fire_mid && i == 40) fire_burst = 1'b1;
      sym();
      fire_burst = 1'b0;
      if (fire_mid && i == 40)
        chk("fire_in_payload_ignored", is_armed, 0);
    end
    payload_valid = 1'b0;
    chk("pready_count", pr_cnt, n_pr);
    if (bad >= 0) chk("underrun_set", underrun, 1);
    for (int i = 0; i < 3; i++) begin
      push(1'b0, 1'b1, 1'b0);
      sym();
    end
    for (int i = 0; i < 7; i++) begin
      push(1'b1, 1'b0, 1'b0);
      sym();
    end
    chk("done_low_in_guard", burst_done, 0);
    push(1'b1, 1'b0, 1'b0);
    next_symbol_strobe = 1'b1;
    @(posedge clock); #1;
    next_symbol_strobe = 1'b0;
    chk("burst_done_pulse", burst_done, 1);
    chk("armed_low_on_done", is_armed, 0);
    if (fire_done) fire_burst = 1'b1;
    @(posedge clock); #1;
    fire_burst = 1'b0;
    chk("done_one_cycle", burst_done, 0);
    chk("armed_after_done", is_armed, 1);
    chk("underrun_sticky", underrun, (bad >= 0));
  endtask

  initial begin : monitor
    bit   prev;
    bit   pend;
    exp_t e;
    exp_t pe;
    prev = 1'b1;
    pend = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev = 1'b1;
        pend = 1'b0;
        continue;
      end
      if (pend) chk("symbol", current_symbol, pe.sym);
      pend = 1'b0;
      if (next_symbol_strobe && !prev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_empty: edge with no expectation at %0t",
                   $time);
        end else begin
          e = exp_q.pop_front();
          chk("tx_enable", rfchain_tx_enable, e.txen);
          chk("rf_i", rfchain_inphase, e.txen ? 8'h3C : 8'h00);
          chk("rf_q", rfchain_quadrature, e.txen ? 8'hC3 : 8'h00);
          chk("payload_ready", payload_ready, e.pr);
          pe = e;
          pend = 1'b1;
        end
      end else begin
        chk("pready_idle", payload_ready, 0);
      end
      if (payload_ready) pr_cnt++;
      prev = next_symbol_strobe;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    repeat (3) @(posedge clock);
    #1;
    chk("reset_symbol", current_symbol, 1);
    chk("reset_armed", is_armed, 0);
    chk("reset_underrun", underrun, 0);
    chk("reset_done", burst_done, 0);
    chk("reset_txen", rfchain_tx_enable, 0);
    chk("reset_iq", rfchain_inphase, 0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    push(1'b1, 1'b0, 1'b0);
    sym();
    chk("armed_after_1_edge", is_armed, 0);
    push(1'b1, 1'b0, 1'b0);
    sym();
    chk("armed_after_2_edges", is_armed, 1);

    reset_n = 1'b0;
    flush_model();
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    push(1'b1, 1'b0, 1'b0);
    next_symbol_strobe = 1'b1;
    repeat (10) begin
      @(posedge clock); #1;
    end
    next_symbol_strobe = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
    end
    chk("held_strobe_one_edge", is_armed, 0);
    push(1'b1, 1'b0, 1'b0);
    sym();
    chk("armed_after_held", is_armed, 1);

    burst(-1, 1'b0, -1, 1'b0);
    burst(10, 1'b1, -1, 1'b1);
    burst(-1, 1'b0, -1, 1'b0);
    burst(3, 1'b0, 21, 1'b0);

    push(1'b1, 1'b0, 1'b0);
    sym();
    chk("reprime_1_edge", is_armed, 0);
    push(1'b1, 1'b0, 1'b0);
    sym();
    chk("reprime_2_edges", is_armed, 1);

    repeat (4) @(posedge clock);
    #1;
    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
